// File: rtl/common_cntdown_timer8_if.sv
// Load/control/status bundle for the 8-bit nibble-cascaded countdown timer.
// The master drives loads and tick control; the timer (slave) returns count and status.
interface common_cntdown_timer8_if;
    logic       i_load_valid;
    logic       i_load_ready;
    logic [7:0] i_load_value;
    logic       i_load_reload;
    logic       i_en;
    logic       i_stop;
    logic [7:0] o_count;
    logic       o_busy;
    logic       o_expire;

    modport master (
        output i_load_valid, i_load_value, i_load_reload, i_en, i_stop,
        input  i_load_ready, o_count, o_busy, o_expire
    );

    modport slave (
        input  i_load_valid, i_load_value, i_load_reload, i_en, i_stop,
        output i_load_ready, o_count, o_busy, o_expire
    );
endinterface

// File: rtl/common_cntdown_timer8.sv
// 8-bit countdown timer with one-shot / auto-reload modes, built from two
// cascaded 4-bit nibbles. Expiry is reported as a registered one-cycle pulse.
module common_cntdown_timer8 (
    input  logic                          clk,
    input  logic                          resetn,
    common_cntdown_timer8_if.slave        tmr
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] reload_q, reload_d;
    logic       auto_q, auto_d;
    logic       expire_q, expire_d;
    logic [3:0] lo_dec, hi_dec;

    // High nibble only moves when the low nibble borrows out of 0x0.
    assign lo_dec = count_q[3:0] - 4'd1;
    assign hi_dec = (count_q[3:0] == 4'h0) ? (count_q[7:4] - 4'd1) : count_q[7:4];

    // NOTE: every output of this block is given a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        auto_d   = auto_q;
        expire_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tmr.i_load_valid) begin
                    if (tmr.i_load_value != 8'h00) begin
                        count_d  = tmr.i_load_value;
                        reload_d = tmr.i_load_value;
                        auto_d   = tmr.i_load_reload;
                        state_d  = RUN;
                    end else begin
                        count_d  = 8'h00;
                        expire_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tmr.i_stop) begin
                    count_d = 8'h00;
                    state_d = IDLE;
                end else if (tmr.i_en) begin
                    if (count_q == 8'h01) begin
                        expire_d = 1'b1;
                        if (auto_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = 8'h00;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = {hi_dec, lo_dec};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops sample the same pre-edge values.
    // NOTE: every flop, including the reload register, is reset so status is defined immediately on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= 8'h00;
            reload_q <= 8'h00;
            auto_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            expire_q <= expire_d;
        end
    end

    assign tmr.i_load_ready = (state_q == IDLE);
    assign tmr.o_busy       = (state_q == RUN);
    assign tmr.o_count      = count_q;
    assign tmr.o_expire     = expire_q;

endmodule

// File: tb/tb_common_cntdown_timer8.sv
// Directed bench for common_cntdown_timer8: hand-computed count/expire/busy
// sequences for one-shot, borrow, auto-reload, gating, stop, zero load and reset.
module tb_common_cntdown_timer8;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;

    common_cntdown_timer8_if tif ();

    common_cntdown_timer8 dut (
        .clk    (clk),
        .resetn (resetn),
        .tmr    (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] value, input logic reload);
        tif.i_load_valid  = 1'b1;
        tif.i_load_value  = value;
        tif.i_load_reload = reload;
        step();
        tif.i_load_valid  = 1'b0;
        tif.i_load_value  = 8'h00;
        tif.i_load_reload = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] cnt,
                             input logic busy, input logic exp_pulse);
        check({tag, "_count"}, tif.o_count, cnt);
        check({tag, "_busy"}, {7'd0, tif.o_busy}, {7'd0, busy});
        check({tag, "_expire"}, {7'd0, tif.o_expire}, {7'd0, exp_pulse});
    endtask

    task automatic stop_run();
        tif.i_stop = 1'b1;
        step();
        tif.i_stop = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        n_checks = 0;
        n_pass   = 0;
        tif.i_load_valid  = 1'b0;
        tif.i_load_value  = 8'h00;
        tif.i_load_reload = 1'b0;
        tif.i_en          = 1'b0;
        tif.i_stop        = 1'b0;
        resetn = 1'b0;
        #2;
        check_out("rst", 8'h00, 1'b0, 1'b0);
        check("rst_ready", {7'd0, tif.i_load_ready}, 8'h01);
        step();
        resetn = 1'b1;
        step();

        // One-shot 0x03; a load attempted mid-run must be refused.
        tif.i_en = 1'b1;
        load(8'h03, 1'b0);
        check_out("os0", 8'h03, 1'b1, 1'b0);
        check("os_ready", {7'd0, tif.i_load_ready}, 8'h00);
        tif.i_load_valid = 1'b1;
        tif.i_load_value = 8'h55;
        step();
        tif.i_load_valid = 1'b0;
        check_out("os1", 8'h02, 1'b1, 1'b0);
        step();
        check_out("os2", 8'h01, 1'b1, 1'b0);
        step();
        check_out("os3", 8'h00, 1'b0, 1'b1);
        step();
        check_out("os4", 8'h00, 1'b0, 1'b0);

        // Borrow cases.
        load(8'h10, 1'b0);
        check_out("b10", 8'h10, 1'b1, 1'b0);
        step();
        check_out("b0f", 8'h0F, 1'b1, 1'b0);
        stop_run();
        check_out("bstop", 8'h00, 1'b0, 1'b0);
        load(8'hA0, 1'b0);
        step();
        check("ba1", tif.o_count, 8'h9F);
        for (int i = 0; i < 16; i++) step();
        check_out("ba17", 8'h8F, 1'b1, 1'b0);
        stop_run();

        // Auto-reload 0x02.
        load(8'h02, 1'b1);
        check_out("ar0", 8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            exp_cnt = (i % 2 == 0) ? 8'h01 : 8'h02;
            check_out($sformatf("ar%0d", i + 1), exp_cnt, 1'b1, (i % 2 == 1));
        end
        stop_run();
        check_out("arstop", 8'h00, 1'b0, 1'b0);

        // Gated ticks, then stop at 0x01 with i_en high.
        load(8'h05, 1'b0);
        check("g0", tif.o_count, 8'h05);
        step();
        check("g1", tif.o_count, 8'h04);
        tif.i_en = 1'b0;
        step();
        check("g2", tif.o_count, 8'h04);
        step();
        check_out("g3", 8'h04, 1'b1, 1'b0);
        tif.i_en = 1'b1;
        step();
        check("g4", tif.o_count, 8'h03);
        step();
        step();
        check("g6", tif.o_count, 8'h01);
        stop_run();
        check_out("gstop", 8'h00, 1'b0, 1'b0);
        step();
        check_out("gstop1", 8'h00, 1'b0, 1'b0);

        // Stop in IDLE is ignored and a simultaneous load is taken.
        tif.i_stop = 1'b1;
        load(8'h04, 1'b0);
        check_out("idstop", 8'h04, 1'b1, 1'b0);
        step();
        tif.i_stop = 1'b0;
        check_out("idstop2", 8'h00, 1'b0, 1'b0);

        // Zero load.
        load(8'h00, 1'b1);
        check_out("z0", 8'h00, 1'b0, 1'b1);
        check("z0_ready", {7'd0, tif.i_load_ready}, 8'h01);
        step();
        check_out("z1", 8'h00, 1'b0, 1'b0);

        // Auto-reload with 0x01 pulses every cycle.
        load(8'h01, 1'b1);
        check_out("r1_0", 8'h01, 1'b1, 1'b0);
        step();
        check_out("r1_1", 8'h01, 1'b1, 1'b1);
        step();
        check_out("r1_2", 8'h01, 1'b1, 1'b1);
        stop_run();
        check_out("r1stop", 8'h00, 1'b0, 1'b0);

        // Reset mid-run, asserted between edges.
        load(8'h07, 1'b0);
        step();
        step();
        check("rm2", tif.o_count, 8'h05);
        #2 resetn = 1'b0;
        #1;
        check_out("rm_rst", 8'h00, 1'b0, 1'b0);
        check("rm_ready", {7'd0, tif.i_load_ready}, 8'h01);
        step();
        step();
        resetn = 1'b1;
        load(8'h02, 1'b0);
        check_out("pr0", 8'h02, 1'b1, 1'b0);
        step();
        check_out("pr1", 8'h01, 1'b1, 1'b0);
        step();
        check_out("pr2", 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on run time so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
